// File: rtl/decode_pkg.sv
// Shared RV32I decode constants, ALU codes, execute class encodings and the decoded bundle.
// The optional RV32M decode is enabled by defining DECODE_STAGE_RV32M_EN.
package decode_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CODE_W = 4;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD    = 3'd0;
  localparam logic [2:0] F3_SLL    = 3'd1;
  localparam logic [2:0] F3_SLT    = 3'd2;
  localparam logic [2:0] F3_SLTU   = 3'd3;
  localparam logic [2:0] F3_XOR    = 3'd4;
  localparam logic [2:0] F3_SR     = 3'd5;
  localparam logic [2:0] F3_OR     = 3'd6;
  localparam logic [2:0] F3_AND    = 3'd7;
  localparam logic [2:0] F3_JALR   = 3'd0;
  localparam logic [2:0] F3_FENCE  = 3'd0;
  localparam logic [2:0] F3_FENCEI = 3'd1;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

  localparam logic [CODE_W-1:0] ALU_NONE  = 4'd0;
  localparam logic [CODE_W-1:0] ALU_ADD   = 4'd1;
  localparam logic [CODE_W-1:0] ALU_SUB   = 4'd2;
  localparam logic [CODE_W-1:0] ALU_SLL   = 4'd3;
  localparam logic [CODE_W-1:0] ALU_SLT   = 4'd4;
  localparam logic [CODE_W-1:0] ALU_SLTU  = 4'd5;
  localparam logic [CODE_W-1:0] ALU_XOR   = 4'd6;
  localparam logic [CODE_W-1:0] ALU_SRL   = 4'd7;
  localparam logic [CODE_W-1:0] ALU_SRA   = 4'd8;
  localparam logic [CODE_W-1:0] ALU_OR    = 4'd9;
  localparam logic [CODE_W-1:0] ALU_AND   = 4'd10;
  localparam logic [CODE_W-1:0] ALU_CMP   = 4'd11;
  localparam logic [CODE_W-1:0] ALU_PASSB = 4'd12;

  localparam logic [CODE_W-1:0] NONE_TYPE = 4'd0;
  localparam logic [CODE_W-1:0] AR_TYPE   = 4'd1;
  localparam logic [CODE_W-1:0] LD_TYPE   = 4'd2;
  localparam logic [CODE_W-1:0] ST_TYPE   = 4'd3;
  localparam logic [CODE_W-1:0] DB_TYPE   = 4'd4;
  localparam logic [CODE_W-1:0] J_TYPE    = 4'd5;
  localparam logic [CODE_W-1:0] SYS_TYPE  = 4'd6;
  localparam logic [CODE_W-1:0] M_TYPE    = 4'd7;

  localparam logic [CODE_W-1:0] AR_GENERAL = 4'd0;
  localparam logic [CODE_W-1:0] AR_LUI     = 4'd1;
  localparam logic [CODE_W-1:0] AR_AUIPC   = 4'd2;
  localparam logic [CODE_W-1:0] J_JAL      = 4'd0;
  localparam logic [CODE_W-1:0] J_JALR     = 4'd1;
  localparam logic [CODE_W-1:0] DB_BEQ     = 4'd0;
  localparam logic [CODE_W-1:0] DB_BNE     = 4'd1;
  localparam logic [CODE_W-1:0] DB_BLT     = 4'd4;
  localparam logic [CODE_W-1:0] DB_BGE     = 4'd5;
  localparam logic [CODE_W-1:0] DB_BLTU    = 4'd6;
  localparam logic [CODE_W-1:0] DB_BGEU    = 4'd7;
  localparam logic [CODE_W-1:0] SYS_FENCE  = 4'd0;
  localparam logic [CODE_W-1:0] SYS_ECALL  = 4'd1;
  localparam logic [CODE_W-1:0] SYS_EBREAK = 4'd2;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [XLEN-1:0]   imm;
    logic              use_imm;
    logic [CODE_W-1:0] alu_code;
    logic [CODE_W-1:0] insn_type;
    logic [CODE_W-1:0] sub_type;
    logic              illegal;
  } bundle_t;

  // alt selects SUB/SRA (funct7 bit 5) for the arithmetic funct3 slots
  function automatic logic [CODE_W-1:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    logic [CODE_W-1:0] code;
    case (f3)
      F3_ADD:  code = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  code = ALU_SLL;
      F3_SLT:  code = ALU_SLT;
      F3_SLTU: code = ALU_SLTU;
      F3_XOR:  code = ALU_XOR;
      F3_SR:   code = alt ? ALU_SRA : ALU_SRL;
      F3_OR:   code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/insn_decode.sv
// Combinational RV32I decoder producing one bundle per instruction.
// Defining DECODE_STAGE_RV32M_EN adds M-extension OP decode.
module insn_decode
  import decode_pkg::*;
(
  input  logic [31:0] insn_i,
  output bundle_t     bundle_c_o
);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  logic            ill;
  bundle_t         b;

  assign opc = insn_i[6:0];
  assign f3  = insn_i[14:12];
  assign f7  = insn_i[31:25];

  assign imm_i  = {{20{insn_i[31]}}, insn_i[31:20]};
  assign imm_s  = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
  assign imm_b  = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
  assign imm_u  = {insn_i[31:12], 12'b0};
  assign imm_j  = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
  assign imm_sh = {27'b0, insn_i[24:20]};

  always_comb begin
    ill        = 1'b0;
    b          = '0;
    b.rs1      = insn_i[19:15];
    b.rs2      = insn_i[24:20];
    b.rd       = insn_i[11:7];
    b.alu_code = ALU_NONE;
    b.insn_type = NONE_TYPE;
    b.sub_type = 4'd0;
    case (opc)
      OPC_LUI: begin
        b.insn_type = AR_TYPE; b.sub_type = AR_LUI; b.alu_code = ALU_PASSB;
        b.imm = imm_u; b.use_imm = 1'b1;
      end
      OPC_AUIPC: begin
        b.insn_type = AR_TYPE; b.sub_type = AR_AUIPC; b.alu_code = ALU_ADD;
        b.imm = imm_u; b.use_imm = 1'b1;
      end
      OPC_JAL: begin
        b.insn_type = J_TYPE; b.sub_type = J_JAL; b.alu_code = ALU_ADD; b.imm = imm_j;
      end
      OPC_JALR: begin
        ill = (f3 != F3_JALR);
        b.insn_type = J_TYPE; b.sub_type = J_JALR; b.alu_code = ALU_ADD;
        b.imm = imm_i; b.use_imm = 1'b1;
      end
      OPC_BRANCH: begin
        ill = (f3 == 3'd2) || (f3 == 3'd3);
        b.insn_type = DB_TYPE; b.sub_type = CODE_W'(f3); b.alu_code = ALU_CMP;
        b.imm = imm_b; b.rd = '0;
      end
      OPC_LOAD: begin
        ill = (f3 == 3'd3) || (f3 > 3'd5);
        b.insn_type = LD_TYPE; b.sub_type = CODE_W'(f3); b.alu_code = ALU_ADD;
        b.imm = imm_i; b.use_imm = 1'b1;
      end
      OPC_STORE: begin
        ill = (f3 > 3'd2);
        b.insn_type = ST_TYPE; b.sub_type = CODE_W'(f3); b.alu_code = ALU_ADD;
        b.imm = imm_s; b.use_imm = 1'b1; b.rd = '0;
      end
      OPC_OP_IMM: begin
        b.insn_type = AR_TYPE; b.sub_type = AR_GENERAL; b.use_imm = 1'b1;
        b.alu_code = alu_from_f3(f3, (f3 == F3_SR) && (f7 == F7_ALT));
        if (f3 == F3_SLL) begin
          ill = (f7 != F7_BASE); b.imm = imm_sh;
        end else if (f3 == F3_SR) begin
          ill = (f7 != F7_BASE) && (f7 != F7_ALT); b.imm = imm_sh;
        end else begin
          b.imm = imm_i;
        end
      end
      OPC_OP: begin
        b.insn_type = AR_TYPE; b.sub_type = AR_GENERAL;
        if (f7 == F7_BASE) begin
          b.alu_code = alu_from_f3(f3, 1'b0);
        end else if ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR))) begin
          b.alu_code = alu_from_f3(f3, 1'b1);
`ifdef DECODE_STAGE_RV32M_EN
        end else if (f7 == F7_MULDIV) begin
          b.insn_type = M_TYPE; b.sub_type = CODE_W'(f3); b.alu_code = ALU_NONE;
`endif
        end else begin
          ill = 1'b1;
        end
      end
      OPC_FENCE: begin
        ill = (f3 != F3_FENCE) && (f3 != F3_FENCEI);
        b.insn_type = SYS_TYPE; b.sub_type = SYS_FENCE; b.rd = '0;
      end
      OPC_SYSTEM: begin
        // Only the exact ECALL/EBREAK encodings are supported; CSR ops trap as illegal
        ill = (insn_i != INSN_ECALL) && (insn_i != INSN_EBREAK);
        b.insn_type = SYS_TYPE; b.rd = '0;
        b.sub_type = (insn_i == INSN_EBREAK) ? SYS_EBREAK : SYS_ECALL;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      b.illegal   = 1'b1;
      b.rd        = '0;
      b.imm       = '0;
      b.use_imm   = 1'b0;
      b.alu_code  = ALU_NONE;
      b.insn_type = NONE_TYPE;
      b.sub_type  = 4'd0;
    end
    bundle_c_o = b;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: decodes the fetched instruction and buffers bundles in a small FIFO.
// Build option DECODE_STAGE_RV32M_EN enables M-extension decode in insn_decode.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned PC_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [31:0]                  in_insn,
  input  logic [PC_W-1:0]              in_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PC_W-1:0]              out_pc,
  output logic [4:0]                   out_rs1,
  output logic [4:0]                   out_rs2,
  output logic [4:0]                   out_rd,
  output logic [31:0]                  out_imm,
  output logic                         out_use_imm,
  output logic [3:0]                   out_alu_code,
  output logic [3:0]                   out_insn_type,
  output logic [3:0]                   out_insn_sub_type,
  output logic                         out_illegal,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  bundle_t          dec_bundle;
  bundle_t          head;
  bundle_t          bundle_mem_q [DEPTH];
  logic [PC_W-1:0]  pc_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  insn_decode u_insn_decode (
    .insn_i     (in_insn),
    .bundle_c_o (dec_bundle)
  );

  // Ready depends only on occupancy so a full queue never accepts on a popping cycle
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) begin
      bundle_mem_q[wr_ptr_q] <= dec_bundle;
      pc_mem_q[wr_ptr_q]     <= in_pc;
    end
  end

  assign head              = bundle_mem_q[rd_ptr_q];
  assign out_pc            = pc_mem_q[rd_ptr_q];
  assign out_rs1           = head.rs1;
  assign out_rs2           = head.rs2;
  assign out_rd            = head.rd;
  assign out_imm           = head.imm;
  assign out_use_imm       = head.use_imm;
  assign out_alu_code      = head.alu_code;
  assign out_insn_type     = head.insn_type;
  assign out_insn_sub_type = head.sub_type;
  assign out_illegal       = head.illegal;
  assign count             = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic against a queue-based reference.
// Expectations follow DECODE_STAGE_RV32M_EN when it is defined for the build.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct {
    logic [31:0] pc;
    bundle_t     b;
  } entry_t;

  logic             clk = 1'b0;
  logic             rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]      in_insn;
  logic [PC_W-1:0]  in_pc, out_pc;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic [31:0]      out_imm;
  logic             out_use_imm, out_illegal;
  logic [3:0]       out_alu_code, out_insn_type, out_insn_sub_type;
  logic [CNT_W-1:0] count;
  bundle_t          obs;

  int vectors = 0;
  int miscompares = 0;
  entry_t mq[$];

  always #5 clk = ~clk;

  decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_use_imm(out_use_imm), .out_alu_code(out_alu_code),
    .out_insn_type(out_insn_type), .out_insn_sub_type(out_insn_sub_type),
    .out_illegal(out_illegal), .count(count)
  );

  always_comb begin
    obs.rs1       = out_rs1;
    obs.rs2       = out_rs2;
    obs.rd        = out_rd;
    obs.imm       = out_imm;
    obs.use_imm   = out_use_imm;
    obs.alu_code  = out_alu_code;
    obs.insn_type = out_insn_type;
    obs.sub_type  = out_insn_sub_type;
    obs.illegal   = out_illegal;
  end

  // Reference decode written from the RV32I encoding tables
  function automatic bundle_t ref_decode(input logic [31:0] w);
    bundle_t e;
    logic [3:0] alu_tab [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    int ii, is, ib, ij;
    bit ok;
    alu_tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    ii = int'($signed(w[31:20]));
    is = int'($signed({w[31:25], w[11:7]}));
    ib = int'($signed({w[31], w[7], w[30:25], w[11:8]})) * 2;
    ij = int'($signed({w[31], w[19:12], w[20], w[30:21]})) * 2;
    e = '0;
    e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    ok = 1'b1;
    if (opc == 7'h37) begin
      e.insn_type = AR_TYPE; e.sub_type = AR_LUI; e.alu_code = ALU_PASSB;
      e.imm = w & 32'hFFFF_F000; e.use_imm = 1'b1;
    end else if (opc == 7'h17) begin
      e.insn_type = AR_TYPE; e.sub_type = AR_AUIPC; e.alu_code = ALU_ADD;
      e.imm = w & 32'hFFFF_F000; e.use_imm = 1'b1;
    end else if (opc == 7'h6F) begin
      e.insn_type = J_TYPE; e.sub_type = J_JAL; e.alu_code = ALU_ADD; e.imm = 32'(ij);
    end else if (opc == 7'h67) begin
      ok = (f3 == 3'd0);
      e.insn_type = J_TYPE; e.sub_type = J_JALR; e.alu_code = ALU_ADD;
      e.imm = 32'(ii); e.use_imm = 1'b1;
    end else if (opc == 7'h63) begin
      ok = !(f3 inside {3'd2, 3'd3});
      e.insn_type = DB_TYPE; e.alu_code = ALU_CMP; e.imm = 32'(ib); e.rd = 5'd0;
      e.sub_type = (f3 == 3'd1) ? DB_BNE : 4'(f3);
    end else if (opc == 7'h03) begin
      ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      e.insn_type = LD_TYPE; e.sub_type = 4'(f3); e.alu_code = ALU_ADD;
      e.imm = 32'(ii); e.use_imm = 1'b1;
    end else if (opc == 7'h23) begin
      ok = (f3 <= 3'd2);
      e.insn_type = ST_TYPE; e.sub_type = 4'(f3); e.alu_code = ALU_ADD;
      e.imm = 32'(is); e.use_imm = 1'b1; e.rd = 5'd0;
    end else if (opc == 7'h13) begin
      e.insn_type = AR_TYPE; e.sub_type = AR_GENERAL; e.use_imm = 1'b1;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        e.imm = 32'(w[24:20]);
        ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
        e.alu_code = (f3 == 3'd1) ? ALU_SLL : (w[30] ? ALU_SRA : ALU_SRL);
      end else begin
        e.imm = 32'(ii); e.alu_code = alu_tab[f3];
      end
    end else if (opc == 7'h33) begin
      e.insn_type = AR_TYPE; e.sub_type = AR_GENERAL;
      if (f7 == 7'h00) e.alu_code = alu_tab[f3];
      else if (f7 == 7'h20 && f3 == 3'd0) e.alu_code = ALU_SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) e.alu_code = ALU_SRA;
`ifdef DECODE_STAGE_RV32M_EN
      else if (f7 == 7'h01) begin
        e.insn_type = M_TYPE; e.sub_type = 4'(f3); e.alu_code = ALU_NONE;
      end
`endif
      else ok = 1'b0;
    end else if (opc == 7'h0F) begin
      ok = (f3 <= 3'd1);
      e.insn_type = SYS_TYPE; e.sub_type = SYS_FENCE; e.rd = 5'd0;
    end else if (w == 32'h0000_0073) begin
      e.insn_type = SYS_TYPE; e.sub_type = SYS_ECALL; e.rd = 5'd0;
    end else if (w == 32'h0010_0073) begin
      e.insn_type = SYS_TYPE; e.sub_type = SYS_EBREAK; e.rd = 5'd0;
    end else begin
      ok = 1'b0;
    end
    if (!ok) begin
      e = '0;
      e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.illegal = 1'b1;
    end
    return e;
  endfunction

  // Advance the reference queue with the inputs present at this edge
  function automatic void model_edge();
    entry_t n;
    bit do_push;
    if (flush) begin
      mq.delete();
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      n.pc = in_pc;
      n.b  = ref_decode(in_insn);
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (do_push) mq.push_back(n);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_insn = 32'h0; in_pc = '0;
  endtask

  function automatic logic [31:0] rand_insn();
    logic [6:0] opcs [11];
    logic [31:0] w;
    int sel;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w = $urandom;
    sel = int'($urandom_range(0, 15));
    if (sel < 11) w[6:0] = opcs[sel];
    case ($urandom_range(0, 5))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1)
      w = ($urandom_range(0, 1) == 1) ? 32'h0010_0073 : 32'h0000_0073;
    return w;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    mq.delete();
    repeat (3) @(negedge clk);
    vectors++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: count=%0d out_valid=%0b in_ready=%0b, want 0/0/1", count, out_valid, in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_addi_bne();
    bundle_t e;
    // addi x1, x0, 5 right after reset release: accepted at the first edge
    in_valid = 1'b1; in_insn = 32'h0050_0093; in_pc = 32'h100; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    e = '0; e.rd = 5'd1; e.rs1 = 5'd0; e.rs2 = 5'd5; e.imm = 32'd5; e.use_imm = 1'b1;
    e.insn_type = AR_TYPE; e.sub_type = AR_GENERAL; e.alu_code = ALU_ADD;
    vectors++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 || obs !== e) begin
      miscompares++;
      $display("FAIL addi: valid=%0b pc=%h bundle=%h, want 1 100 %h", out_valid, out_pc, obs, e);
    end
    in_valid = 1'b1; in_insn = 32'hFE20_9EE3; in_pc = 32'h104;
    step();
    in_valid = 1'b0;
    e = '0; e.rd = 5'd0; e.rs1 = 5'd1; e.rs2 = 5'd2; e.imm = 32'hFFFF_FFFC;
    e.insn_type = DB_TYPE; e.sub_type = DB_BNE; e.alu_code = ALU_CMP;
    vectors++;
    if (out_valid !== 1'b1 || count !== CNT_W'(1) || out_pc !== 32'h104 || obs !== e) begin
      miscompares++;
      $display("FAIL bne: valid=%0b count=%0d pc=%h bundle=%h, want 1 1 104 %h", out_valid, count, out_pc, obs, e);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0 || count !== '0) begin
      miscompares++;
      $display("FAIL drain_after_bne: valid=%0b count=%0d, want 0 0", out_valid, count);
    end
  endtask

  task automatic test_illegal_and_m();
    bundle_t e;
    out_ready = 1'b1;
    in_valid = 1'b1; in_insn = 32'hFFFF_FFFF; in_pc = 32'h200;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_illegal !== 1'b1 || out_rd !== 5'd0 || out_insn_type !== NONE_TYPE || out_alu_code !== ALU_NONE) begin
      miscompares++;
      $display("FAIL illegal_ones: ill=%0b rd=%0d type=%0d alu=%0d, want 1 0 %0d %0d",
               out_illegal, out_rd, out_insn_type, out_alu_code, NONE_TYPE, ALU_NONE);
    end
    in_valid = 1'b1; in_insn = 32'h0220_81B3; in_pc = 32'h204;
    step();
    in_valid = 1'b0;
    e = '0; e.rs1 = 5'd1; e.rs2 = 5'd2;
`ifdef DECODE_STAGE_RV32M_EN
    e.rd = 5'd3; e.insn_type = M_TYPE; e.sub_type = 4'd0; e.alu_code = ALU_NONE;
`else
    e.illegal = 1'b1;
`endif
    vectors++;
    if (out_valid !== 1'b1 || obs !== e) begin
      miscompares++;
      $display("FAIL mul_decode: valid=%0b bundle=%h, want 1 %h", out_valid, obs, e);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs [3];
    pcs = '{32'h300, 32'h304, 32'h308};
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_insn = 32'h0000_0013 | (32'(i + 1) << 7); in_pc = pcs[i];
      step();
    end
    vectors++;
    if (count !== CNT_W'(2) || in_ready !== 1'b0 || out_pc !== pcs[0]) begin
      miscompares++;
      $display("FAIL full_hold: count=%0d in_ready=%0b head=%h, want 2 0 %h", count, in_ready, out_pc, pcs[0]);
    end
    // Still offering the third: the pop cycle at full must not accept it
    out_ready = 1'b1;
    step();
    vectors++;
    if (count !== CNT_W'(1) || out_pc !== pcs[1] || out_rd !== 5'd2) begin
      miscompares++;
      $display("FAIL drain_first: count=%0d head=%h rd=%0d, want 1 %h 2", count, out_pc, out_rd, pcs[1]);
    end
    step();
    vectors++;
    if (count !== CNT_W'(1) || out_pc !== pcs[2] || out_rd !== 5'd3) begin
      miscompares++;
      $display("FAIL third_accept: count=%0d head=%h rd=%0d, want 1 %h 3", count, out_pc, out_rd, pcs[2]);
    end
    in_valid = 1'b0;
    step();
    vectors++;
    if (count !== '0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty: count=%0d valid=%0b, want 0 0", count, out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_insn = 32'h0010_0093; in_pc = 32'h400 + 32'(4 * i);
      step();
    end
    flush = 1'b1; in_insn = 32'h0020_0093; in_pc = 32'h408;
    step();
    flush = 1'b0; in_valid = 1'b0;
    vectors++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush: count=%0d valid=%0b in_ready=%0b, want 0 0 1", count, out_valid, in_ready);
    end
    step();
    vectors++;
    if (count !== '0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_drop: count=%0d valid=%0b, want 0 0", count, out_valid);
    end
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_insn = 32'h0000_0033; in_pc = 32'h500 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    mq.delete();
    #1;
    vectors++;
    if (count !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: count=%0d valid=%0b in_ready=%0b, want 0 0 1", count, out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_insn = 32'h0000_0037; in_pc = 32'h600;
    step();
    in_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || count !== CNT_W'(1) || out_pc !== 32'h600) begin
      miscompares++;
      $display("FAIL first_accept: valid=%0b count=%0d pc=%h, want 1 1 600", out_valid, count, out_pc);
    end
    out_ready = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_insn   = rand_insn();
      in_pc     = $urandom;
      step();
      vectors++;
      if (count !== CNT_W'(mq.size()) || out_valid !== (mq.size() != 0) ||
          in_ready !== (mq.size() < DEPTH)) begin
        miscompares++;
        $display("FAIL rand_ctrl[%0d]: count=%0d valid=%0b in_ready=%0b, want count %0d", n, count, out_valid, in_ready, mq.size());
      end
      if (mq.size() != 0) begin
        vectors++;
        if (out_pc !== mq[0].pc || obs !== mq[0].b) begin
          miscompares++;
          $display("FAIL rand_head[%0d]: pc=%h bundle=%h, want %h %h", n, out_pc, obs, mq[0].pc, mq[0].b);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_addi_bne();
    test_illegal_and_m();
    test_back_to_back();
    test_flush();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, giving the number of decoded-bundle queue entries (power of two, >=2).
REQ-002 SHALL have parameter PC_W, default 32, giving the program-counter width.
REQ-003 SHALL have these ports (name  direction  width  meaning):
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous active-low reset
  flush  in  1  discard queue contents and the current input
  in_valid  in  1  fetch offers an instruction
  in_ready  out  1  stage accepts an instruction
  in_insn  in  32  raw RV32I instruction
  in_pc  in  PC_W  instruction address
  out_valid  out  1  head bundle valid
  out_ready  in  1  execute consumes the head bundle
  out_pc  out  PC_W  pc of the head bundle
  out_rs1, out_rs2, out_rd  out  5 each  register indices
  out_imm  out  32  sign/zero-extended immediate
  out_use_imm  out  1  ALU operand B is the immediate
  out_alu_code  out  4  ALU operation
  out_insn_type, out_insn_sub_type  out  4 each  execute class and subclass
  out_illegal  out  1  instruction not decodable
  count  out  $clog2(DEPTH+1)  occupied entries
REQ-004 SHALL use one clock; reset SHALL be asynchronous and active-low.

Function
REQ-005 SHALL decode in_insn combinationally and write the full bundle into the queue when in_valid && in_ready.
REQ-006 SHALL drive in_ready = (count < DEPTH), independent of out_ready; a full queue accepts nothing, even in a cycle that pops.
REQ-007 SHALL pop the head when out_valid && out_ready; out_valid = (count != 0); outputs SHALL be registered queue-head contents.
REQ-008 Latency: an instruction accepted at edge N SHALL be visible with out_valid=1 after edge N when the queue was empty; order SHALL be FIFO.
REQ-009 Simultaneous push and pop (not full) SHALL leave count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-010 flush SHALL zero count and both pointers at the next edge, drop that cycle's input, and take priority over push and pop.
REQ-011 Immediates: U-type {insn[31:12],12'b0}; I, S, B, J per the RV32I sign-extension rules; SLLI/SRLI/SRAI SHALL use zero-extended shamt insn[24:20].
REQ-012 out_rd SHALL be 0 for branches, stores, FENCE, SYSTEM and illegal instructions.
REQ-013 BNE SHALL have its own sub-type DB_BNE, distinct from DB_BEQ.
REQ-014 out_use_imm SHALL be 1 for LUI, AUIPC, OP-IMM, loads, stores and JALR, and 0 otherwise.
REQ-015 Unknown opcode, unknown funct3/funct7, or a shift-immediate with a nonzero illegal funct7 SHALL set out_illegal=1, with insn_type NONE_TYPE and alu_code NONE.
REQ-016 FENCE/FENCE.I SHALL decode as SYS_TYPE/SYS_FENCE; ECALL/EBREAK SHALL decode as SYS_TYPE/SYS_ECALL and SYS_EBREAK; CSR instructions SHALL decode as illegal.

Reset
REQ-017 rst_n low SHALL immediately force count=0, pointers=0, out_valid=0 and in_ready=1, including mid-operation; queue payload need not be reset.
REQ-018 After rst_n rises, the first accept SHALL be possible at the next rising edge.

Configuration
REQ-019 Macro DECODE_STAGE_RV32M_EN: when defined, OP with funct7=0000001 SHALL decode as M_TYPE, with sub-type = funct3, use_imm=0 and rd=insn[11:7]; when undefined, such encodings SHALL be illegal.

Structure
REQ-020 Package decode_pkg SHALL hold the opcode, funct3 and funct7 constants, the ALU codes, and the insn_type/sub_type constants, including DB_BNE, SYS_* and M_TYPE.
REQ-021 A combinational sub-module insn_decode SHALL map (insn) to the bundle; decode_stage SHALL hold only the queue and handshake.

Verification
REQ-022 0x00500093 at pc 0x100, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, use_imm=1, AR_TYPE/AR_GENERAL, ADD.
REQ-023 0xFE209EE3 (bne x1,x2,-4) -> rd=0, rs1=1, rs2=2, imm=0xFFFFFFFC, DB_TYPE/DB_BNE, CMP.
REQ-024 out_ready=0, three back-to-back offers -> two accepted, count=2, in_ready=0; then out_ready=1 -> both drain in order, third accepted.
REQ-025 count=2 with flush=1 and in_valid=1 -> next cycle count=0, out_valid=0, input dropped.
REQ-026 0xFFFFFFFF -> out_illegal=1, rd=0; 0x022081B3 -> M_TYPE, sub 0, rd=3 with the macro, illegal without.
REQ-027 rst_n low while count=2 -> same-cycle out_valid=0, count=0, in_ready=1.
